// File: rtl/axil_pkg.sv
// Shared widths, response codes and FSM state types for the AXI4-Lite register slave.
package axil_pkg;

    localparam int unsigned AXIL_DATA_W = 32;
    localparam int unsigned AXIL_STRB_W = 4;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {
        WAccept,
        WResp
    } wr_state_t;

    typedef enum logic [0:0] {
        RAccept,
        RResp
    } rd_state_t;

endpackage

// File: rtl/axil_s_wr_ctrl.sv
// AXI4-Lite write-side control: independent AW/W capture, commit strobe and B response.
module axil_s_wr_ctrl
    import axil_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           NUM_REGS   = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [ADDR_WIDTH-1:0]  awaddr_i,
    input  logic                   awvalid_i,
    output logic                   awready_o,
    input  logic [AXIL_DATA_W-1:0] wdata_i,
    input  logic [AXIL_STRB_W-1:0] wstrb_i,
    input  logic                   wvalid_i,
    output logic                   wready_o,
    output resp_t                  bresp_o,
    output logic                   bvalid_o,
    input  logic                   bready_i,
    output logic                   commit_o,
    output logic [ADDR_WIDTH-1:0]  addr_o,
    output logic [AXIL_DATA_W-1:0] data_o,
    output logic [AXIL_STRB_W-1:0] strb_o,
    output logic                   in_range_o
);

    wr_state_t              state_q, state_d;
    logic                   alive_q;
    logic                   aw_got_q, aw_got_d;
    logic                   w_got_q, w_got_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [AXIL_DATA_W-1:0] data_q, data_d;
    logic [AXIL_STRB_W-1:0] strb_q, strb_d;
    logic                   bvalid_q, bvalid_d;
    resp_t                  bresp_q, bresp_d;

    logic                   aw_hs, w_hs, commit, in_range;
    logic [ADDR_WIDTH-1:0]  word_idx;

    // alive_q holds the readies low until the first edge after reset release
    assign awready_o = alive_q && (state_q == WAccept) && !aw_got_q;
    assign wready_o  = alive_q && (state_q == WAccept) && !w_got_q;
    assign aw_hs     = awvalid_i && awready_o;
    assign w_hs      = wvalid_i && wready_o;

    // Commit may use a beat arriving this very cycle, so bypass the latches
    assign addr_o = aw_got_q ? addr_q : awaddr_i;
    assign data_o = w_got_q ? data_q : wdata_i;
    assign strb_o = w_got_q ? strb_q : wstrb_i;
    assign commit = (state_q == WAccept) && (aw_got_q || aw_hs) && (w_got_q || w_hs);

    assign word_idx   = (addr_o - BASE_ADDR) >> 2;
    assign in_range   = (addr_o >= BASE_ADDR) && (word_idx < ADDR_WIDTH'(NUM_REGS));
    assign in_range_o = in_range;
    assign commit_o   = commit;
    assign bvalid_o   = bvalid_q;
    assign bresp_o    = bresp_q;

    always_comb begin
        state_d  = state_q;
        aw_got_d = aw_got_q;
        w_got_d  = w_got_q;
        addr_d   = addr_q;
        data_d   = data_q;
        strb_d   = strb_q;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        unique case (state_q)
            WAccept: begin
                if (aw_hs) begin
                    aw_got_d = 1'b1;
                    addr_d   = awaddr_i;
                end
                if (w_hs) begin
                    w_got_d = 1'b1;
                    data_d  = wdata_i;
                    strb_d  = wstrb_i;
                end
                if (commit) begin
                    aw_got_d = 1'b0;
                    w_got_d  = 1'b0;
                    bvalid_d = 1'b1;
                    bresp_d  = in_range ? RESP_OKAY : RESP_SLVERR;
                    state_d  = WResp;
                end
            end
            WResp: begin
                if (bready_i) begin
                    bvalid_d = 1'b0;
                    state_d  = WAccept;
                end
            end
            default: state_d = WAccept;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= WAccept;
            alive_q  <= 1'b0;
            aw_got_q <= 1'b0;
            w_got_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            strb_q   <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            state_q  <= state_d;
            alive_q  <= 1'b1;
            aw_got_q <= aw_got_d;
            w_got_q  <= w_got_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            strb_q   <= strb_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
        end
    end

endmodule

// File: rtl/axil_regfile_s.sv
// AXI4-Lite slave register bank: NUM_REGS byte-strobed registers, flat readout and write pulses.
module axil_regfile_s
    import axil_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           NUM_REGS   = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                            aclk,
    input  logic                            reset,
    input  logic [ADDR_WIDTH-1:0]           s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [AXIL_DATA_W-1:0]          s_axi_wdata,
    input  logic [AXIL_STRB_W-1:0]          s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]           s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [AXIL_DATA_W-1:0]          s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [AXIL_DATA_W*NUM_REGS-1:0] regs_o,
    output logic [NUM_REGS-1:0]             reg_wr_o
);

    localparam int unsigned IdxW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [AXIL_DATA_W-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]    reg_wr_q;

    logic                   wr_commit, wr_in_range;
    logic [ADDR_WIDTH-1:0]  wr_addr, wr_word;
    logic [AXIL_DATA_W-1:0] wr_data;
    logic [AXIL_STRB_W-1:0] wr_strb;
    logic [IdxW-1:0]        wr_idx;
    resp_t                  bresp;

    rd_state_t              rd_state_q, rd_state_d;
    logic                   alive_q;
    logic                   rvalid_q, rvalid_d;
    logic [AXIL_DATA_W-1:0] rdata_q, rdata_d;
    resp_t                  rresp_q, rresp_d;
    logic [ADDR_WIDTH-1:0]  rd_word;
    logic [IdxW-1:0]        rd_idx;
    logic                   rd_in_range;

    logic                   unused_bits;

    axil_s_wr_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .BASE_ADDR  (BASE_ADDR)
    ) u_wr_ctrl (
        .clk_i      (aclk),
        .reset_i    (reset),
        .awaddr_i   (s_axi_awaddr),
        .awvalid_i  (s_axi_awvalid),
        .awready_o  (s_axi_awready),
        .wdata_i    (s_axi_wdata),
        .wstrb_i    (s_axi_wstrb),
        .wvalid_i   (s_axi_wvalid),
        .wready_o   (s_axi_wready),
        .bresp_o    (bresp),
        .bvalid_o   (s_axi_bvalid),
        .bready_i   (s_axi_bready),
        .commit_o   (wr_commit),
        .addr_o     (wr_addr),
        .data_o     (wr_data),
        .strb_o     (wr_strb),
        .in_range_o (wr_in_range)
    );

    assign s_axi_bresp = bresp;

    assign wr_word     = (wr_addr - BASE_ADDR) >> 2;
    assign wr_idx      = wr_word[IdxW-1:0];
    assign rd_word     = (s_axi_araddr - BASE_ADDR) >> 2;
    assign rd_idx      = rd_word[IdxW-1:0];
    assign rd_in_range = (s_axi_araddr >= BASE_ADDR) && (rd_word < ADDR_WIDTH'(NUM_REGS));

    assign unused_bits = ^{wr_word[ADDR_WIDTH-1:IdxW], rd_word[ADDR_WIDTH-1:IdxW],
                           s_axi_awprot, s_axi_arprot};

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            reg_wr_q <= '0;
        end else begin
            reg_wr_q <= '0;
            if (wr_commit && wr_in_range) begin
                reg_wr_q[wr_idx] <= 1'b1;
                for (int k = 0; k < AXIL_STRB_W; k++) begin
                    if (wr_strb[k]) begin
                        regs_q[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
                    end
                end
            end
        end
    end

    assign reg_wr_o = reg_wr_q;

    always_comb begin
        regs_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_o[AXIL_DATA_W*i +: AXIL_DATA_W] = regs_q[i];
        end
    end

    assign s_axi_arready = alive_q && (rd_state_q == RAccept);
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

    // Sampling regs_q (not the write bypass) gives pre-write data on a same-cycle collision
    always_comb begin
        rd_state_d = rd_state_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        unique case (rd_state_q)
            RAccept: begin
                if (s_axi_arvalid && s_axi_arready) begin
                    rvalid_d   = 1'b1;
                    rdata_d    = rd_in_range ? regs_q[rd_idx] : '0;
                    rresp_d    = rd_in_range ? RESP_OKAY : RESP_SLVERR;
                    rd_state_d = RResp;
                end
            end
            RResp: begin
                if (s_axi_rready) begin
                    rvalid_d   = 1'b0;
                    rd_state_d = RAccept;
                end
            end
            default: rd_state_d = RAccept;
        endcase
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            rd_state_q <= RAccept;
            alive_q    <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            alive_q    <= 1'b1;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

endmodule

// File: tb/tb_axil_regfile_s.sv
// Directed self-checking bench for axil_regfile_s with the default 8-register map at address 0.
module tb_axil_regfile_s;

    logic         aclk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  s_axi_awaddr = '0;
    logic [2:0]   s_axi_awprot = '0;
    logic         s_axi_awvalid = 1'b0;
    logic         s_axi_awready;
    logic [31:0]  s_axi_wdata = '0;
    logic [3:0]   s_axi_wstrb = '0;
    logic         s_axi_wvalid = 1'b0;
    logic         s_axi_wready;
    logic [1:0]   s_axi_bresp;
    logic         s_axi_bvalid;
    logic         s_axi_bready = 1'b0;
    logic [31:0]  s_axi_araddr = '0;
    logic [2:0]   s_axi_arprot = '0;
    logic         s_axi_arvalid = 1'b0;
    logic         s_axi_arready;
    logic [31:0]  s_axi_rdata;
    logic [1:0]   s_axi_rresp;
    logic         s_axi_rvalid;
    logic         s_axi_rready = 1'b0;
    logic [255:0] regs_o;
    logic [7:0]   reg_wr_o;

    int total = 0;
    int bad   = 0;

    logic [255:0] exp_regs;

    axil_regfile_s dut (
        .aclk          (aclk),
        .reset         (reset),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awprot  (s_axi_awprot),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arprot  (s_axi_arprot),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .regs_o        (regs_o),
        .reg_wr_o      (reg_wr_o)
    );

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Drive AW after aw_dly cycles and W after w_dly cycles; returns one cycle after the later one.
    task automatic wr_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input logic [7:0] exp_wr);
        int cyc = 0;
        bit aw_done = 0, w_done = 0, aw_now, w_now;
        s_axi_awaddr = a;
        s_axi_wdata  = d;
        s_axi_wstrb  = s;
        while (!(aw_done && w_done) && cyc < 32) begin
            s_axi_awvalid = !aw_done && (cyc >= aw_dly);
            s_axi_wvalid  = !w_done && (cyc >= w_dly);
            aw_now = s_axi_awvalid && s_axi_awready;
            w_now  = s_axi_wvalid && s_axi_wready;
            chk("b_early", s_axi_bvalid, 0);
            if (aw_done) chk("awready_latched", s_axi_awready, 0);
            if (w_done) chk("wready_latched", s_axi_wready, 0);
            step();
            aw_done |= aw_now;
            w_done  |= w_now;
            cyc++;
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        chk("wr_hs_done", {aw_done, w_done}, 2'b11);
        chk("bvalid_lat", s_axi_bvalid, 1);
        chk("reg_wr_pulse", reg_wr_o, exp_wr);
    endtask

    task automatic wr_resp(input int hold, input logic [1:0] exp_resp);
        for (int i = 0; i < hold; i++) begin
            chk("bvalid_hold", s_axi_bvalid, 1);
            chk("bresp_hold", s_axi_bresp, exp_resp);
            chk("awready_bhold", s_axi_awready, 0);
            chk("wready_bhold", s_axi_wready, 0);
            step();
        end
        chk("bvalid", s_axi_bvalid, 1);
        chk("bresp", s_axi_bresp, exp_resp);
        s_axi_bready = 1'b1;
        step();
        s_axi_bready = 1'b0;
        chk("bvalid_clr", s_axi_bvalid, 0);
        chk("reg_wr_clr", reg_wr_o, 0);
        chk("awready_back", s_axi_awready, 1);
        chk("wready_back", s_axi_wready, 1);
    endtask

    task automatic rd_req(input logic [31:0] a);
        int cyc = 0;
        bit done = 0, now;
        s_axi_araddr  = a;
        s_axi_arvalid = 1'b1;
        while (!done && cyc < 32) begin
            now = s_axi_arready;
            step();
            done = now;
            cyc++;
        end
        s_axi_arvalid = 1'b0;
        chk("rd_hs_done", done, 1);
        chk("rvalid_lat", s_axi_rvalid, 1);
        chk("arready_busy", s_axi_arready, 0);
    endtask

    task automatic rd_resp(input int hold, input logic [31:0] exp_d, input logic [1:0] exp_r);
        for (int i = 0; i < hold; i++) begin
            chk("rvalid_hold", s_axi_rvalid, 1);
            chk("rdata_hold", s_axi_rdata, exp_d);
            chk("arready_rhold", s_axi_arready, 0);
            step();
        end
        chk("rvalid", s_axi_rvalid, 1);
        chk("rdata", s_axi_rdata, exp_d);
        chk("rresp", s_axi_rresp, exp_r);
        s_axi_rready = 1'b1;
        step();
        s_axi_rready = 1'b0;
        chk("rvalid_clr", s_axi_rvalid, 0);
        chk("arready_back", s_axi_arready, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_awready"}, s_axi_awready, 0);
        chk({tag, "_wready"}, s_axi_wready, 0);
        chk({tag, "_arready"}, s_axi_arready, 0);
        chk({tag, "_bvalid"}, s_axi_bvalid, 0);
        chk({tag, "_bresp"}, s_axi_bresp, 0);
        chk({tag, "_rvalid"}, s_axi_rvalid, 0);
        chk({tag, "_rdata"}, s_axi_rdata, 0);
        chk({tag, "_rresp"}, s_axi_rresp, 0);
        chk({tag, "_regs"}, regs_o, 0);
        chk({tag, "_reg_wr"}, reg_wr_o, 0);
    endtask

    initial begin
        // Reset state and ready release timing
        step();
        step();
        chk_all_zero("rst");
        reset = 1'b0;
        chk("rdy_release_aw", s_axi_awready, 0);
        step();
        chk("rdy_up_aw", s_axi_awready, 1);
        chk("rdy_up_w", s_axi_wready, 1);
        chk("rdy_up_ar", s_axi_arready, 1);

        // 1: full write and read-back of reg1
        wr_req(32'h0000_0004, 32'hdead_beef, 4'hF, 0, 0, 8'h02);
        chk("t1_regs1", regs_o[63:32], 32'hdead_beef);
        wr_resp(0, 2'b00);
        rd_req(32'h0000_0004);
        rd_resp(0, 32'hdead_beef, 2'b00);

        // 2: low-half strobe
        wr_req(32'h0000_0004, 32'h0000_c0de, 4'b0011, 0, 0, 8'h02);
        wr_resp(0, 2'b00);
        rd_req(32'h0000_0004);
        rd_resp(0, 32'hdead_c0de, 2'b00);

        // 3: W first, AW first, simultaneous
        wr_req(32'h0000_0008, 32'h0000_0011, 4'hF, 3, 0, 8'h04);
        wr_resp(0, 2'b00);
        wr_req(32'h0000_000c, 32'h0000_0022, 4'hF, 0, 2, 8'h08);
        wr_resp(0, 2'b00);
        wr_req(32'h0000_0010, 32'h0000_0033, 4'hF, 0, 0, 8'h10);
        wr_resp(0, 2'b00);
        chk("t3_regs2", regs_o[95:64], 32'h0000_0011);
        chk("t3_regs3", regs_o[127:96], 32'h0000_0022);
        chk("t3_regs4", regs_o[159:128], 32'h0000_0033);

        // wstrb=0 in range: pulse and OKAY, no data change
        wr_req(32'h0000_0010, 32'hffff_ffff, 4'h0, 0, 0, 8'h10);
        wr_resp(0, 2'b00);
        chk("strb0_regs4", regs_o[159:128], 32'h0000_0033);

        // 4: out of range
        exp_regs = {32'h0, 32'h0, 32'h0, 32'h33, 32'h22, 32'h11, 32'hdead_c0de, 32'h0};
        wr_req(32'h0000_0020, 32'h1234_5678, 4'hF, 0, 0, 8'h00);
        wr_resp(0, 2'b10);
        chk("t4_regs", regs_o, exp_regs);
        rd_req(32'h0000_0020);
        rd_resp(0, 32'h0, 2'b10);

        // 5: backpressure with a queued AW
        wr_req(32'h0000_0008, 32'h5555_aaaa, 4'hF, 0, 0, 8'h04);
        rd_req(32'h0000_0008);
        s_axi_awaddr  = 32'h0000_000c;
        s_axi_wdata   = 32'h7777_0000;
        s_axi_wstrb   = 4'hF;
        s_axi_awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t5_bvalid", s_axi_bvalid, 1);
            chk("t5_bresp", s_axi_bresp, 2'b00);
            chk("t5_rvalid", s_axi_rvalid, 1);
            chk("t5_rdata", s_axi_rdata, 32'h5555_aaaa);
            chk("t5_rresp", s_axi_rresp, 2'b00);
            chk("t5_awready", s_axi_awready, 0);
            chk("t5_wready", s_axi_wready, 0);
            chk("t5_arready", s_axi_arready, 0);
            step();
        end
        s_axi_bready = 1'b1;
        step();
        s_axi_bready = 1'b0;
        chk("t5_b_done", s_axi_bvalid, 0);
        chk("t5_aw_now_ready", s_axi_awready, 1);
        step();
        s_axi_awvalid = 1'b0;
        chk("t5_aw_taken", s_axi_awready, 0);
        chk("t5_no_commit", s_axi_bvalid, 0);
        s_axi_wvalid = 1'b1;
        step();
        s_axi_wvalid = 1'b0;
        chk("t5_q_bvalid", s_axi_bvalid, 1);
        chk("t5_q_pulse", reg_wr_o, 8'h08);
        wr_resp(0, 2'b00);
        chk("t5_regs3", regs_o[127:96], 32'h7777_0000);
        rd_resp(0, 32'h5555_aaaa, 2'b00);

        // Same-cycle read and write of reg1 returns the old value
        s_axi_awaddr  = 32'h0000_0004;
        s_axi_wdata   = 32'hffff_0000;
        s_axi_wstrb   = 4'hF;
        s_axi_araddr  = 32'h0000_0004;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        s_axi_arvalid = 1'b1;
        step();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_arvalid = 1'b0;
        chk("col_bvalid", s_axi_bvalid, 1);
        chk("col_pulse", reg_wr_o, 8'h02);
        wr_resp(0, 2'b00);
        rd_resp(0, 32'hdead_c0de, 2'b00);
        chk("col_regs1", regs_o[63:32], 32'hffff_0000);

        // 6: reset with both responses pending
        wr_req(32'h0000_0000, 32'habcd_0123, 4'hF, 0, 0, 8'h01);
        rd_req(32'h0000_0004);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("t6");
        step();
        step();
        reset = 1'b0;
        chk("t6_rdy_low_aw", s_axi_awready, 0);
        chk("t6_rdy_low_ar", s_axi_arready, 0);
        step();
        chk("t6_rdy_aw", s_axi_awready, 1);
        chk("t6_rdy_w", s_axi_wready, 1);
        chk("t6_rdy_ar", s_axi_arready, 1);
        chk("t6_bvalid", s_axi_bvalid, 0);
        rd_req(32'h0000_0004);
        rd_resp(0, 32'h0, 2'b00);
        chk("t6_regs", regs_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
